// File: rtl/uart_tx_wb_if.sv
// Wishbone slave bus bundle for the UART transmitter.
//
// Signal names keep the slave-side view (_i driven by the master, _o driven
// by the slave) so waveforms read the same as a flat port list.
//   wbs_cyc_i / wbs_stb_i / wbs_we_i : cycle, strobe, write enable
//   wbs_sel_i [3:0]                  : byte lane selects
//   wbs_adr_i [31:0]                 : byte address (only [3:2] decoded)
//   wbs_dat_i [31:0]                 : write data
//   wbs_ack_o                        : one-cycle registered acknowledge
//   wbs_dat_o [31:0]                 : read data, valid only with ack
//
// Handshake: the master raises cyc&stb with address/data stable and keeps
// them stable until it sees ack. The slave accepts in the first cycle cyc&stb
// is sampled high while ack is low, and answers with exactly one ack cycle on
// the next cycle. A master that keeps stb high through the ack cycle gets its
// next transfer accepted one cycle later, so every transfer costs two cycles.
interface uart_tx_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/uart_tx_wb.sv
// UART transmitter (8N1, LSB first) with a small TX FIFO behind a Wishbone
// slave register interface.
//
// Ports:
//   clk_i        system clock
//   rstn_i       synchronous active-low reset
//   wbs          Wishbone slave bundle (uart_tx_wb_if.slave)
//   uart_tx_o    serial line, idle high
//   irq_o        level interrupt: irq_en & FIFO empty & transmitter idle
//   dbg_state_o  current transmitter FSM state (IDLE=0 START=1 DATA=2 STOP=3)
//
// Register map (adr[3:2]):
//   0 TXDATA  write-only, sel[0] pushes dat[7:0]; reads 0
//   1 STATUS  [0] busy [1] full [2] empty [3] overflow [12:8] count;
//             writing dat[3]=1 with sel[0] clears overflow
//   2 CTRL    [15:0] divisor (bit period = divisor+1 clocks), [16] irq_en
//   3 reserved, reads 0, writes ignored
module uart_tx_wb #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  uart_tx_wb_if.slave     wbs,
  output logic            uart_tx_o,
  output logic            irq_o,
  output logic [1:0]      dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------- state
  state_e         state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           irq_q;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q;

  logic [15:0]    div_q;
  logic           irq_en_q;

  logic           ack_q;
  logic [31:0]    dat_o_q, dat_o_d;

  // ---------------------------------------------------------------- bus decode
  logic        acc;
  logic        wr_acc, rd_acc;
  logic [1:0]  reg_sel;
  logic        push_req, push, pop;
  logic        full, empty, busy;
  logic [4:0]  count5;
  logic [31:0] rd_data;

  // Accept only when no ack is outstanding; this is what forces the idle
  // cycle between back-to-back transfers.
  assign acc     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign wr_acc  = acc & wbs.wbs_we_i;
  assign rd_acc  = acc & ~wbs.wbs_we_i;
  assign reg_sel = wbs.wbs_adr_i[3:2];

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign busy   = (state_q != S_IDLE);
  assign count5 = 5'(count_q);

  assign push_req = wr_acc & (reg_sel == 2'd0) & wbs.wbs_sel_i[0];
  // A simultaneous pop frees the slot the push needs, so full only blocks a
  // push when the transmitter is not taking a byte this cycle.
  assign push     = push_req & (~full | pop);

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      2'd1:    rd_data = {19'd0, count5, 4'd0, ovf_q, empty, full, busy};
      2'd2:    rd_data = {15'd0, irq_en_q, div_q};
      default: rd_data = 32'd0;
    endcase
  end

  assign dat_o_d = rd_acc ? rd_data : 32'd0;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack_q   <= 1'b0;
      dat_o_q <= 32'd0;
    end else begin
      ack_q   <= acc;
      dat_o_q <= dat_o_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_o_q;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      div_q    <= DIV_RESET;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_acc && reg_sel == 2'd2) begin
        if (wbs.wbs_sel_i[0]) div_q[7:0]  <= wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) div_q[15:8] <= wbs.wbs_dat_i[15:8];
        if (wbs.wbs_sel_i[2]) irq_en_q    <= wbs.wbs_dat_i[16];
      end
      if (push_req && full && !pop) begin
        ovf_q <= 1'b1;
      end else if (wr_acc && reg_sel == 2'd1 && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wbs.wbs_dat_i[7:0];
  end

  // ---------------------------------------------------------------- TX FSM
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_en_q & empty & ~busy;
    end
  end

  // baud_q counts down from the divisor; reaching zero marks the last cycle
  // of a bit. Reloading from div_q at each boundary lets a divisor change
  // take effect from the next bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = div_q;
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          baud_d  = div_q;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d  = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is registered from the next state so uart_tx_o comes
  // straight from a flop and changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx_o   = tx_q;
  assign irq_o       = irq_q;
  assign dbg_state_o = state_q;

  // Bus bits outside the decoded fields.
  logic unused_bus;
  assign unused_bus = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                        wbs.wbs_dat_i[31:17], wbs.wbs_sel_i[3]};

endmodule

// File: doc/uart_tx_wb.md
UART_TX_WB -- requirements
Module: uart_tx_wb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: TX FIFO entries, power of two, 2..16.
REQ-002 Parameter DIV_RESET, default 16'd433: reset value of the bit-period divisor.
REQ-003 clk_i  in  1  system clock (wb_clk_i domain).
REQ-004 rstn_i  in  1  reset, synchronous and active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave cycle, strobe and write-enable; the block sits on internal mux slot 2.
REQ-006 wbs_sel_i  in  4  byte lane selects.
REQ-007 wbs_adr_i  in  32  byte address; only bits [3:2] are decoded.
REQ-008 wbs_dat_i  in  32  write data.
REQ-009 wbs_ack_o  out  1  transfer acknowledge.
REQ-010 wbs_dat_o  out  32  read data.
REQ-011 uart_tx_o  out  1  serial line, 8N1, LSB first, idle high.
REQ-012 irq_o  out  1  level interrupt, asserted when the transmitter has drained.

Function
REQ-013 Register map (adr[3:2]):
- 0 TXDATA, write-only, reads 0.
- 1 STATUS: [0] busy, [1] full, [2] empty, [3] overflow, [8+:5] fifo count, other bits 0.
- 2 CTRL: [15:0] divisor, [16] irq_en.
- 3 reserved: reads 0, writes ignored.
REQ-014 Ack timing: wbs_ack_o pulses exactly one cycle, registered, in the cycle after cyc&stb is first sampled high. It is forced low the following cycle, so back-to-back transfers take 2 cycles each.
REQ-015 wbs_dat_o is valid in the ack cycle and 0 otherwise.
REQ-016 Register side effects occur only in the cycle the access is accepted (cyc&stb&!ack).
REQ-017 TXDATA write with sel[0]=1 pushes wbs_dat_i[7:0]; sel[0]=0 has no effect.
REQ-018 A push while count==FIFO_DEPTH with no pop in the same cycle drops the byte and sets overflow.
- overflow is sticky; it clears only on a STATUS write with dat[3]=1 and sel[0]=1.
- A push and a pop in the same cycle while full: the push is accepted and count is unchanged.
REQ-019 CTRL writes obey the byte lanes: sel[0] updates divisor[7:0], sel[1] updates divisor[15:8], sel[2] updates irq_en.
REQ-020 Bit period is divisor+1 clk_i cycles; divisor 0 gives a 1-cycle bit.
- The baud counter reloads from the current divisor at every bit boundary.
- A divisor change mid-frame takes effect from the next bit.
REQ-021 FSM states IDLE, START, DATA, STOP:
- IDLE: uart_tx_o=1. If the FIFO is non-empty, pop the head into the shifter and go to START next cycle.
- START: uart_tx_o=0 for one bit period, then DATA.
- DATA: shifter[0] for one bit period per bit, shift right; after 8 bits go to STOP.
- STOP: uart_tx_o=1 for one bit period, then IDLE.
REQ-022 With the FIFO non-empty at the end of STOP, IDLE lasts exactly 1 cycle, so the frame period is 10*(divisor+1)+1 cycles.
REQ-023 busy = (state != IDLE); empty = (count == 0); full = (count == FIFO_DEPTH).
REQ-024 irq_o = irq_en & empty & !busy, registered, 1-cycle latency.
REQ-025 The FIFO is circular; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 When rstn_i=0 at a clock edge, the following take these values:
- wbs_ack_o=0, wbs_dat_o=0, uart_tx_o=1, irq_o=0.
- state=IDLE, count=0, pointers=0, overflow=0.
- divisor=DIV_RESET, irq_en=0.
REQ-027 A reset asserted mid-frame aborts the frame: uart_tx_o=1 from the next edge, FIFO contents discarded. A Wishbone cycle in flight receives no ack.

Verification
REQ-028 Single frame: CTRL=0x3 (4 cycles/bit), write TXDATA=0x55 -> uart_tx_o = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles total), then busy=0.
REQ-029 Overflow: FIFO_DEPTH=4, CTRL=0xFF, six back-to-back TXDATA writes 0x01..0x06 -> 0x01 goes to the shifter, 0x02..0x05 are queued, 0x06 is dropped. STATUS reads full=1, overflow=1, count=4. The line transmits 0x01..0x05 only.
REQ-030 Overflow clear: STATUS write 0x8 -> next STATUS read shows overflow=0 with count unchanged.
REQ-031 Interrupt: CTRL=0x10000 (irq_en, divisor 0), write 0xA5 -> irq_o falls within 2 cycles of the write ack and rises 1 cycle after the STOP bit ends (frame = 10 cycles).
REQ-032 Reset mid-frame: rstn_i=0 for 1 cycle during DATA bit 3 -> uart_tx_o=1 next edge, STATUS reads 0x4 (empty), CTRL reads DIV_RESET.
REQ-033 Access checks:
- sel=4'b0010 write to TXDATA -> no push.
- Read from adr 0xC -> 0.
- Every transfer is acked exactly once, 1 cycle after the strobe.
